spi_slave_regfile_crc: RTL and testbench

- SPI slave with an internal register file. All logic runs in the clk domain: sck/csn/si are oversampled through synchronisers, and the block handles addressed read and write frames.
- Successor to the fixed 24-bit single-word SPI/CRC slave. Adds:
  - parametrised data width, depth and SPI mode (CPOL/CPHA);
  - a command/address phase;
  - CRC-8 checking on writes and CRC generation on reads;
  - framing-error detection and a saturating error counter.
- Sits between the external SPI pins and on-chip logic. On-chip logic reads the register file through a local read port.

---
 rtl/spi_regfile_pkg.sv | 23 ++
 rtl/crc8_serial.sv | 39 +++
 rtl/spi_slave_regfile_crc.sv | 265 ++++++++++++++++++++++++++
 tb/tb_spi_slave_regfile_crc.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI slave register file with CRC-8 framing.
package spi_regfile_pkg;

    // Frame-level FSM states
    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StWcrc,
        StRdata,
        StRcrc,
        StDone
    } state_e;

    // Bit position of the read/write flag inside the CMD byte
    localparam int unsigned CMD_RD = 7;

    // Total frame length in bits: CMD byte + data word + CRC byte
    function automatic int unsigned frame_len(input int unsigned data_w);
        return 16 + data_w;
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB first, no reflection, no final XOR).
module crc8_serial #(
    parameter logic [7:0] POLY = 8'h1D,
    parameter logic [7:0] INIT = 8'hFF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       init,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q, crc_d;
    logic       fb;

    // Next CRC: reseed has priority over a shift-in
    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[7] ^ bit_in;
        if (init) begin
            crc_d = INIT;
        end else if (en) begin
            crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
        end
    end

    // CRC register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/spi_slave_regfile_crc.sv
// SPI slave fronting a register file; CRC-8 checked on writes, appended on reads.
module spi_slave_regfile_crc
    import spi_regfile_pkg::*;
#(
    parameter int unsigned         DATA_W   = 24,
    parameter int unsigned         ADDR_W   = 5,
    parameter bit                  CPOL     = 1'b0,
    parameter bit                  CPHA     = 1'b0,
    parameter logic [7:0]          CRC_POLY = 8'h1D,
    parameter logic [7:0]          CRC_INIT = 8'hFF,
    parameter logic [DATA_W-1:0]   RST_VAL  = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sck,
    input  logic              csn,
    input  logic              si,
    output logic              so,
    input  logic [ADDR_W-1:0] loc_addr,
    output logic [DATA_W-1:0] loc_rd_data,
    output logic              wr_done,
    output logic              crc_err,
    output logic              frame_err,
    output logic [7:0]        err_cnt,
    output logic              busy
);

    localparam int unsigned Depth       = 2 ** ADDR_W;
    localparam logic [6:0]  FrameLen    = 7'(frame_len(DATA_W));
    localparam logic [6:0]  LastCmdBit  = 7'd7;
    localparam logic [6:0]  RdFlagBit   = 7'(7 - CMD_RD);
    localparam logic [6:0]  LastDataBit = 7'(8 + DATA_W - 1);
    localparam logic [6:0]  LastBit     = FrameLen - 7'd1;
    localparam bit          SampleRise  = (CPOL == CPHA);

    // Synchronisers: [1] is the synchronised level, [2] its previous value
    logic [2:0] sck_sync_q, sck_sync_d;
    logic [2:0] csn_sync_q, csn_sync_d;
    logic [1:0] si_sync_q, si_sync_d;

    state_e              state_q, state_d;
    logic [6:0]          bit_cnt_q, bit_cnt_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [7:0]          rx_crc_q, rx_crc_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic                so_q, so_d;
    logic                wr_done_q, wr_done_d;
    logic                crc_err_q, crc_err_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   loc_rd_data_q, loc_rd_data_d;
    logic [DATA_W-1:0]   mem_q [Depth];
    logic [DATA_W-1:0]   mem_d [Depth];

    logic                si_s, sck_rise, sck_fall, sample_edge, shift_edge;
    logic                csn_fall, csn_rise, commit;
    logic                crc_init, crc_en, crc_bit;
    logic [7:0]          crc;
    logic [ADDR_W-1:0]   addr_next;

    // Edge detection on synchronised pins
    always_comb begin
        sck_sync_d  = {sck_sync_q[1:0], sck};
        csn_sync_d  = {csn_sync_q[1:0], csn};
        si_sync_d   = {si_sync_q[0], si};
        si_s        = si_sync_q[1];
        sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
        sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
        sample_edge = SampleRise ? sck_rise : sck_fall;
        shift_edge  = SampleRise ? sck_fall : sck_rise;
        csn_fall    = ~csn_sync_q[1] & csn_sync_q[2];
        csn_rise    = csn_sync_q[1] & ~csn_sync_q[2];
        busy_d      = ~csn_sync_q[1];
    end

    crc8_serial #(
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .clk    (clk),
        .rstn   (rstn),
        .init   (crc_init),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    // Frame FSM, shift registers and commit decision
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        rx_shift_d  = rx_shift_q;
        rx_crc_d    = rx_crc_q;
        tx_shift_d  = tx_shift_q;
        so_d        = so_q;
        wr_done_d   = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        commit      = 1'b0;
        crc_init    = 1'b0;
        crc_en      = 1'b0;
        crc_bit     = si_s;
        // Address including the bit being sampled right now
        addr_next   = ADDR_W'({addr_q, si_s});

        if (state_q == StIdle) begin
            // A csn rise seen here belongs to a frame cut by reset; ignore it
            so_d = 1'b0;
            if (csn_fall) begin
                state_d   = StCmd;
                bit_cnt_d = '0;
                crc_init  = 1'b1;
            end
        end else if (csn_rise) begin
            state_d = StIdle;
            so_d    = 1'b0;
            if (bit_cnt_q != FrameLen) begin
                frame_err_d = 1'b1;
            end else if (!rd_q) begin
                if (rx_crc_q == crc) begin
                    commit    = 1'b1;
                    wr_done_d = 1'b1;
                end else begin
                    crc_err_d = 1'b1;
                end
            end
        end else begin
            if (sample_edge && bit_cnt_q != 7'h7F) begin
                bit_cnt_d = bit_cnt_q + 7'd1;
            end
            unique case (state_q)
                StCmd: begin
                    if (sample_edge) begin
                        crc_en = 1'b1;
                        addr_d = addr_next;
                        if (bit_cnt_q == RdFlagBit) begin
                            rd_d = si_s;
                        end
                        if (bit_cnt_q == LastCmdBit) begin
                            tx_shift_d = mem_q[addr_next];
                            state_d    = rd_q ? StRdata : StWdata;
                        end
                    end
                end
                StWdata: begin
                    if (sample_edge) begin
                        crc_en     = 1'b1;
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], si_s};
                        if (bit_cnt_q == LastDataBit) begin
                            state_d = StWcrc;
                        end
                    end
                end
                StWcrc: begin
                    if (sample_edge) begin
                        rx_crc_d = {rx_crc_q[6:0], si_s};
                        if (bit_cnt_q == LastBit) begin
                            state_d = StDone;
                        end
                    end
                end
                StRdata: begin
                    if (shift_edge) begin
                        so_d       = tx_shift_q[DATA_W-1];
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                        crc_en     = 1'b1;
                        crc_bit    = tx_shift_q[DATA_W-1];
                    end
                    if (sample_edge && bit_cnt_q == LastDataBit) begin
                        tx_shift_d      = '0;
                        tx_shift_d[7:0] = crc;
                        state_d         = StRcrc;
                    end
                end
                StRcrc: begin
                    if (shift_edge) begin
                        so_d       = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                    if (sample_edge && bit_cnt_q == LastBit) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (shift_edge) begin
                        so_d = 1'b0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Error counter, memory write-back and local read port
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((crc_err_d || frame_err_d) && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        mem_d = mem_q;
        if (commit) begin
            mem_d[addr_q] = rx_shift_q;
        end
        loc_rd_data_d = mem_q[loc_addr];
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sync_q    <= {3{CPOL}};
            csn_sync_q    <= '0;
            si_sync_q     <= '0;
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            rd_q          <= 1'b0;
            addr_q        <= '0;
            rx_shift_q    <= '0;
            rx_crc_q      <= '0;
            tx_shift_q    <= '0;
            so_q          <= 1'b0;
            wr_done_q     <= 1'b0;
            crc_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            err_cnt_q     <= '0;
            busy_q        <= 1'b0;
            loc_rd_data_q <= RST_VAL;
            mem_q         <= '{default: RST_VAL};
        end else begin
            sck_sync_q    <= sck_sync_d;
            csn_sync_q    <= csn_sync_d;
            si_sync_q     <= si_sync_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rd_q          <= rd_d;
            addr_q        <= addr_d;
            rx_shift_q    <= rx_shift_d;
            rx_crc_q      <= rx_crc_d;
            tx_shift_q    <= tx_shift_d;
            so_q          <= so_d;
            wr_done_q     <= wr_done_d;
            crc_err_q     <= crc_err_d;
            frame_err_q   <= frame_err_d;
            err_cnt_q     <= err_cnt_d;
            busy_q        <= busy_d;
            loc_rd_data_q <= loc_rd_data_d;
            mem_q         <= mem_d;
        end
    end

    assign so          = so_q;
    assign loc_rd_data = loc_rd_data_q;
    assign wr_done     = wr_done_q;
    assign crc_err     = crc_err_q;
    assign frame_err   = frame_err_q;
    assign err_cnt     = err_cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_regfile_crc.sv
// Bench: four DUTs, one per SPI mode (index = {CPOL, CPHA}), driven by a bit-level master.
module tb_spi_slave_regfile_crc;

    localparam int H = 6;  // sck half period in clk cycles

    typedef struct {
        int wr;
        int ce;
        int fe;
    } pexp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  sck_v = 4'b1100;
    logic [3:0]  csn_v = 4'b1111;
    logic [3:0]  si_v = 4'b0000;
    logic [4:0]  loc_addr = '0;
    wire  [3:0]  so_v, busy_v, wr_v, ce_v, fe_v;
    wire  [23:0] rd_w [4];
    wire  [7:0]  ec_w [4];

    int    wr_n [4];
    int    ce_n [4];
    int    fe_n [4];
    int    checks = 0;
    int    errors = 0;
    pexp_t pq [$];
    logic [31:0] dq [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_regfile_crc #(
            .DATA_W (24),
            .ADDR_W (5),
            .CPOL   (g >= 2),
            .CPHA   (g % 2 == 1)
        ) u_dut (
            .clk         (clk),
            .rstn        (rstn),
            .sck         (sck_v[g]),
            .csn         (csn_v[g]),
            .si          (si_v[g]),
            .so          (so_v[g]),
            .loc_addr    (loc_addr),
            .loc_rd_data (rd_w[g]),
            .wr_done     (wr_v[g]),
            .crc_err     (ce_v[g]),
            .frame_err   (fe_v[g]),
            .err_cnt     (ec_w[g]),
            .busy        (busy_v[g])
        );
    end

    // Pulse counters per DUT
    initial begin
        for (int k = 0; k < 4; k++) begin
            wr_n[k] = 0;
            ce_n[k] = 0;
            fe_n[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_v[k]) wr_n[k]++;
            if (ce_v[k]) ce_n[k]++;
            if (fe_v[k]) fe_n[k]++;
        end
    end

    function automatic logic [7:0] crc8_model(input logic [31:0] v);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ v[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h1D;
        end
        return c;
    endfunction

    function automatic logic [47:0] wr_frame(input logic [4:0] a, input logic [23:0] d,
                                             input logic [7:0] x);
        logic [31:0] body;
        body = {3'b000, a, d};
        return {8'h00, body, crc8_model(body) ^ x};
    endfunction

    function automatic logic [47:0] rd_frame(input logic [4:0] a);
        return {8'h00, 3'b100, a, 32'h0};
    endfunction

    // Bit-level SPI master; returns bits captured from so, MSB first
    task automatic spi_frame(input int m, input logic [47:0] tx, input int nbits,
                             output logic [47:0] rx);
        logic cpol, cpha;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        rx   = '0;
        csn_v[m] = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                si_v[m] = tx[nbits-1-i];
                repeat (H) @(negedge clk);
                sck_v[m] = ~cpol;
                rx = {rx[46:0], so_v[m]};
                repeat (H) @(negedge clk);
                sck_v[m] = cpol;
            end else begin
                sck_v[m] = ~cpol;
                si_v[m]  = tx[nbits-1-i];
                repeat (H) @(negedge clk);
                sck_v[m] = cpol;
                rx = {rx[46:0], so_v[m]};
                repeat (H) @(negedge clk);
            end
        end
        repeat (H) @(negedge clk);
        csn_v[m] = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Frame plus pulse deltas observed while it ran
    task automatic frame_io(input int m, input logic [47:0] tx, input int nbits,
                            output logic [47:0] rx, output int dw, output int dc, output int df);
        int bw, bc, bf;
        bw = wr_n[m];
        bc = ce_n[m];
        bf = fe_n[m];
        spi_frame(m, tx, nbits, rx);
        dw = wr_n[m] - bw;
        dc = ce_n[m] - bc;
        df = fe_n[m] - bf;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (so_v !== 4'b0 || busy_v !== 4'b0) begin
            errors++;
            $display("FAIL reset_so_busy so=%b busy=%b expected 0000/0000", so_v, busy_v);
        end
        checks++;
        if (ec_w[0] !== 8'd0 || wr_v !== 4'b0 || ce_v !== 4'b0 || fe_v !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs err_cnt=%0d wr=%b ce=%b fe=%b expected 0", ec_w[0],
                     wr_v, ce_v, fe_v);
        end
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (rd_w[0] !== 24'h0 || busy_v !== 4'b0 || fe_n[0] !== 0) begin
            errors++;
            $display("FAIL reset_release rd=%h busy=%b fe=%0d expected 000000/0000/0", rd_w[0],
                     busy_v, fe_n[0]);
        end
    endtask

    task automatic test_write(input int m, input logic [4:0] a, input logic [23:0] d,
                              input logic [7:0] x, input logic [23:0] mem_exp,
                              input logic [7:0] ec_exp, input string name);
        logic [47:0] rx;
        int dw, dc, df;
        pexp_t e;
        pq.push_back('{wr: (x == 0) ? 1 : 0, ce: (x == 0) ? 0 : 1, fe: 0});
        frame_io(m, wr_frame(a, d, x), 40, rx, dw, dc, df);
        e = pq.pop_front();
        checks++;
        if (dw !== e.wr || dc !== e.ce || df !== e.fe) begin
            errors++;
            $display("FAIL %s_pulses wr/ce/fe=%0d/%0d/%0d expected %0d/%0d/%0d", name, dw, dc,
                     df, e.wr, e.ce, e.fe);
        end
        loc_addr = a;
        repeat (3) @(negedge clk);
        checks++;
        if (rd_w[m] !== mem_exp) begin
            errors++;
            $display("FAIL %s_mem got %h expected %h", name, rd_w[m], mem_exp);
        end
        checks++;
        if (ec_w[m] !== ec_exp) begin
            errors++;
            $display("FAIL %s_err_cnt got %0d expected %0d", name, ec_w[m], ec_exp);
        end
    endtask

    task automatic test_read(input int m, input logic [4:0] a, input logic [23:0] d,
                             input string name);
        logic [47:0] rx;
        logic [31:0] exp;
        int dw, dc, df;
        dq.push_back({d, crc8_model({3'b100, a, d})});
        frame_io(m, rd_frame(a), 40, rx, dw, dc, df);
        exp = dq.pop_front();
        checks++;
        if (rx[31:0] !== exp) begin
            errors++;
            $display("FAIL %s_data got %h expected %h", name, rx[31:0], exp);
        end
        checks++;
        if (dw !== 0 || dc !== 0 || df !== 0 || rx[39:32] !== 8'h00) begin
            errors++;
            $display("FAIL %s_quiet wr/ce/fe=%0d/%0d/%0d cmd_so=%h expected 0/0/0/00", name,
                     dw, dc, df, rx[39:32]);
        end
    endtask

    task automatic test_abort();
        logic [47:0] rx;
        int dw, dc, df;
        pq.push_back('{wr: 0, ce: 0, fe: 1});
        frame_io(0, wr_frame(5'd4, 24'h777777, 8'h00) >> 20, 20, rx, dw, dc, df);
        begin
            pexp_t e;
            e = pq.pop_front();
            checks++;
            if (dw !== e.wr || dc !== e.ce || df !== e.fe) begin
                errors++;
                $display("FAIL abort_pulses wr/ce/fe=%0d/%0d/%0d expected %0d/%0d/%0d", dw, dc,
                         df, e.wr, e.ce, e.fe);
            end
        end
        loc_addr = 5'd4;
        repeat (3) @(negedge clk);
        checks++;
        if (rd_w[0] !== 24'h0 || ec_w[0] !== 8'd2) begin
            errors++;
            $display("FAIL abort_state mem=%h err_cnt=%0d expected 000000/2", rd_w[0], ec_w[0]);
        end
    endtask

    task automatic test_modes();
        for (int m = 0; m < 4; m++) begin
            test_write(m, 5'd31, 24'hA5A5A5, 8'h00, 24'hA5A5A5, (m == 0) ? 8'd2 : 8'd0, "mode_wr");
            test_read(m, 5'd31, 24'hA5A5A5, "mode_rd");
        end
    endtask

    task automatic test_reset_mid_read();
        logic [47:0] rx;
        int dw, dc, df;
        fork
            frame_io(0, rd_frame(5'd5), 40, rx, dw, dc, df);
            begin
                repeat (H + 2 * H * 14) @(negedge clk);
                rstn = 1'b0;
                repeat (3) @(negedge clk);
                checks++;
                if (so_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_so_busy so=%b busy=%b expected 0/0", so_v[0],
                             busy_v[0]);
                end
                rstn = 1'b1;
            end
        join
        checks++;
        if (dw !== 0 || dc !== 0 || df !== 0 || ec_w[0] !== 8'd0) begin
            errors++;
            $display("FAIL midreset_quiet wr/ce/fe=%0d/%0d/%0d err_cnt=%0d expected 0/0/0/0", dw,
                     dc, df, ec_w[0]);
        end
        loc_addr = 5'd5;
        repeat (3) @(negedge clk);
        checks++;
        if (rd_w[0] !== 24'h0) begin
            errors++;
            $display("FAIL midreset_mem got %h expected 000000", rd_w[0]);
        end
        test_write(0, 5'd7, 24'h0F1E2D, 8'h00, 24'h0F1E2D, 8'd0, "post_reset_wr");
    endtask

    task automatic test_saturation();
        int bf;
        bf = fe_n[0];
        for (int i = 1; i <= 256; i++) begin
            csn_v[0] = 1'b0;
            repeat (6) @(negedge clk);
            csn_v[0] = 1'b1;
            repeat (6) @(negedge clk);
            if (i == 254 || i == 255 || i == 256) begin
                checks++;
                if (ec_w[0] !== ((i == 254) ? 8'd254 : 8'd255)) begin
                    errors++;
                    $display("FAIL sat_err_cnt after %0d errors got %0d expected %0d", i, ec_w[0],
                             (i == 254) ? 254 : 255);
                end
            end
        end
        checks++;
        if (fe_n[0] - bf !== 256) begin
            errors++;
            $display("FAIL sat_frame_err pulses got %0d expected 256", fe_n[0] - bf);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write(0, 5'd5, 24'h123456, 8'h00, 24'h123456, 8'd0, "mode0_wr");
        test_read(0, 5'd5, 24'h123456, "readback");
        test_write(0, 5'd3, 24'hABCDEF, 8'h01, 24'h000000, 8'd1, "crc_err");
        test_abort();
        test_modes();
        test_reset_mid_read();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
